// File: rtl/dlwc_loop_sequencer_if.sv
// Command/result bundle for dlwc_loop_sequencer. The status fields exist only
// when DLWC_SEQ_STATUS_EN is defined.
interface dlwc_loop_sequencer_if #(
    parameter int DW = 8,
    parameter int CW = 4
);
    // Both channels use valid/ready: a transfer happens on a rising clk edge
    // where valid and ready are both high. start_ready is high only in IDLE.
    logic          start_valid;
    logic          start_ready;
    logic [CW-1:0] cmd_limit;
    logic [CW-1:0] cmd_break_at;
    logic [CW-1:0] cmd_continue_at;
    logic [DW-1:0] cmd_data;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sum;
`ifdef DLWC_SEQ_STATUS_EN
    logic [1:0]    exit_cause;
    logic [CW:0]   iter_count;
`endif

    modport master (
        output start_valid, cmd_limit, cmd_break_at, cmd_continue_at, cmd_data, out_ready,
        input  start_ready, busy, out_valid, out_sum
`ifdef DLWC_SEQ_STATUS_EN
        , input exit_cause, iter_count
`endif
    );

    modport slave (
        input  start_valid, cmd_limit, cmd_break_at, cmd_continue_at, cmd_data, out_ready,
        output start_ready, busy, out_valid, out_sum
`ifdef DLWC_SEQ_STATUS_EN
        , output exit_cause, iter_count
`endif
    );
endinterface

// File: rtl/dlwc_loop_sequencer.sv
// Break/continue loop-accumulate sequencer: one loop iteration per clock.
// Optional status outputs (exit_cause, iter_count) under DLWC_SEQ_STATUS_EN.
module dlwc_loop_sequencer #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dlwc_loop_sequencer_if.slave bus,
    output logic [1:0]           dbg_state_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW:0]   i_q, i_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [CW-1:0] limit_q, limit_d;
    logic [CW-1:0] brk_q, brk_d;
    logic [CW-1:0] cont_q, cont_d;
    logic [DW-1:0] data_q, data_d;
`ifdef DLWC_SEQ_STATUS_EN
    logic [1:0]    cause_q, cause_d;
    logic [CW:0]   cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            sum_q   <= '0;
            limit_q <= '0;
            brk_q   <= '0;
            cont_q  <= '0;
            data_q  <= '0;
`ifdef DLWC_SEQ_STATUS_EN
            cause_q <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            sum_q   <= sum_d;
            limit_q <= limit_d;
            brk_q   <= brk_d;
            cont_q  <= cont_d;
            data_q  <= data_d;
`ifdef DLWC_SEQ_STATUS_EN
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        sum_d   = sum_q;
        limit_d = limit_q;
        brk_d   = brk_q;
        cont_d  = cont_q;
        data_d  = data_q;
`ifdef DLWC_SEQ_STATUS_EN
        cause_d = cause_q;
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    limit_d = bus.cmd_limit;
                    brk_d   = bus.cmd_break_at;
                    cont_d  = bus.cmd_continue_at;
                    data_d  = bus.cmd_data;
                    sum_d   = '0;
                    i_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Limit check comes first so break/continue indices at or past
                // the limit can never fire; i is one bit wider to avoid wrap.
                if (i_q >= {1'b0, limit_q}) begin
                    state_d = ST_DONE;
`ifdef DLWC_SEQ_STATUS_EN
                    cause_d = (limit_q == '0) ? 2'b10 : 2'b00;
                    cnt_d   = i_q;
`endif
                end else if (i_q == {1'b0, brk_q}) begin
                    sum_d   = sum_q | data_q;
                    state_d = ST_DONE;
`ifdef DLWC_SEQ_STATUS_EN
                    cause_d = 2'b01;
                    cnt_d   = i_q + (CW+1)'(1);
`endif
                end else begin
                    if (i_q == {1'b0, cont_q}) begin
                        sum_d = sum_q + DW'(limit_q);
                    end else begin
                        case (i_q[1:0])
                            2'b00:   sum_d = sum_q + data_q;
                            2'b01:   sum_d = sum_q ^ data_q;
                            2'b10:   sum_d = sum_q & data_q;
                            default: sum_d = sum_q | data_q;
                        endcase
                    end
                    i_d = i_q + (CW+1)'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.start_ready = (state_q == ST_IDLE);
    assign bus.busy        = (state_q == ST_RUN);
    assign bus.out_valid   = (state_q == ST_DONE);
    assign bus.out_sum     = sum_q;
`ifdef DLWC_SEQ_STATUS_EN
    assign bus.exit_cause  = cause_q;
    assign bus.iter_count  = cnt_q;
`endif
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_dlwc_loop_sequencer.sv
// Self-checking bench for dlwc_loop_sequencer: scoreboard of expected results
// produced by a behavioural loop model, compared when out_valid rises.
module tb_dlwc_loop_sequencer;
  localparam int DW = 8;
  localparam int CW = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  dlwc_loop_sequencer_if #(.DW(DW), .CW(CW)) bus ();

  dlwc_loop_sequencer #(.DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [1:0]    exp_cause_q[$];
  logic [CW:0]   exp_cnt_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Behavioural reference of one command, straight from the loop description.
  task automatic model(input logic [CW-1:0] lim, input logic [CW-1:0] brk,
                       input logic [CW-1:0] cont, input logic [DW-1:0] d,
                       output logic [DW-1:0] s, output int cyc,
                       output logic [1:0] cause, output logic [CW:0] cnt);
    s = '0; cyc = 0; cause = 2'b11; cnt = '0;
    for (int i = 0; i <= 16; i++) begin
      cyc++;
      if (i >= int'(lim)) begin
        cause = (lim == 0) ? 2'b10 : 2'b00;
        cnt = (CW+1)'(i);
        break;
      end
      if (i == int'(brk)) begin
        s = s | d;
        cause = 2'b01;
        cnt = (CW+1)'(i + 1);
        break;
      end
      if (i == int'(cont)) s = s + DW'(lim);
      else begin
        case (i % 4)
          0: s = s + d;
          1: s = s ^ d;
          2: s = s & d;
          default: s = s | d;
        endcase
      end
    end
  endtask

  task automatic drive_idle();
    bus.start_valid     = 1'b0;
    bus.cmd_limit       = '0;
    bus.cmd_break_at    = '0;
    bus.cmd_continue_at = '0;
    bus.cmd_data        = '0;
    bus.out_ready       = 1'b0;
  endtask

  // Drives one command, collects its result and hands it back. hold>0 keeps
  // out_ready low for that many cycles in DONE with a stray start pulse.
  task automatic run_cmd(input logic [CW-1:0] lim, input logic [CW-1:0] brk,
                         input logic [CW-1:0] cont, input logic [DW-1:0] d,
                         input int hold);
    logic [DW-1:0] s;
    int            cyc;
    int            got_cyc;
    logic [1:0]    cause;
    logic [CW:0]   cnt;
    logic [DW-1:0] e_sum;
    int            wait_n;
    logic [1:0]    e_cause;
    logic [CW:0]   e_cnt;
    int            e_cyc;

    @(negedge clk);
    wait_n = 0;
    while (!bus.start_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (!bus.start_ready) check("start_ready_timeout", 32'd0, 32'd1);

    bus.cmd_limit       = lim;
    bus.cmd_break_at    = brk;
    bus.cmd_continue_at = cont;
    bus.cmd_data        = d;
    bus.start_valid     = 1'b1;
    bus.out_ready       = 1'b0;
    model(lim, brk, cont, d, s, cyc, cause, cnt);
    exp_q.push_back(s);
    exp_cyc_q.push_back(cyc);
    exp_cause_q.push_back(cause);
    exp_cnt_q.push_back(cnt);

    @(posedge clk);
    #1;
    bus.start_valid     = 1'b0;
    bus.cmd_limit       = CW'($urandom_range(0, 15));
    bus.cmd_break_at    = CW'($urandom_range(0, 15));
    bus.cmd_continue_at = CW'($urandom_range(0, 15));
    bus.cmd_data        = DW'($urandom_range(0, 255));

    got_cyc = 0;
    while (got_cyc < 40) begin
      @(posedge clk);
      #1;
      got_cyc++;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
      void'(exp_cause_q.pop_front());
      void'(exp_cnt_q.pop_front());
      return;
    end

    e_sum   = exp_q.pop_front();
    e_cyc   = exp_cyc_q.pop_front();
    e_cause = exp_cause_q.pop_front();
    e_cnt   = exp_cnt_q.pop_front();
    check("out_sum", 32'(bus.out_sum), 32'(e_sum));
    check("run_cycles", 32'(got_cyc), 32'(e_cyc));
    check("start_ready_in_done", 32'(bus.start_ready), 32'd0);
`ifdef DLWC_SEQ_STATUS_EN
    check("exit_cause", 32'(bus.exit_cause), 32'(e_cause));
    check("iter_count", 32'(bus.iter_count), 32'(e_cnt));
`else
    if (e_cause == 2'b11 || e_cnt > 16) check("model_status", 32'd0, 32'd1);
`endif

    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      bus.start_valid = (k == 3);
      @(posedge clk);
      #1;
      check("hold_sum", 32'(bus.out_sum), 32'(e_sum));
      check("hold_valid", 32'(bus.out_valid), 32'd1);
    end
    if (hold > 0) check("hold_start_ready", 32'(bus.start_ready), 32'd0);

    // Handshake edge with a coincident start that must be ignored.
    @(negedge clk);
    bus.out_ready   = 1'b1;
    bus.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready   = 1'b0;
    bus.start_valid = 1'b0;
    check("after_hs_start_ready", 32'(bus.start_ready), 32'd1);
    check("after_hs_busy", 32'(bus.busy), 32'd0);
    check("after_hs_out_valid", 32'(bus.out_valid), 32'd0);
    check("after_hs_sum_hold", 32'(bus.out_sum), 32'(e_sum));
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef DLWC_SEQ_STATUS_EN
    check("rst_exit_cause", 32'(bus.exit_cause), 32'd0);
    check("rst_iter_count", 32'(bus.iter_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_cmd(4'd4,  4'd15, 4'd15, 8'h0F, 0);
    run_cmd(4'd8,  4'd2,  4'd1,  8'h05, 0);
    run_cmd(4'd0,  4'd0,  4'd0,  8'hAA, 0);
    run_cmd(4'd15, 4'd15, 4'd15, 8'hFF, 0);
    run_cmd(4'd6,  4'd3,  4'd3,  8'h3C, 10);
    run_cmd(4'd5,  4'd0,  4'd0,  8'h81, 0);

    // Random commands
    for (int n = 0; n < 8; n++) begin
      run_cmd(CW'($urandom_range(0, 15)), CW'($urandom_range(0, 15)),
              CW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)), 0);
    end

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    bus.cmd_limit       = 4'd15;
    bus.cmd_break_at    = 4'd15;
    bus.cmd_continue_at = 4'd15;
    bus.cmd_data        = 8'h77;
    bus.start_valid     = 1'b1;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_sum", 32'(bus.out_sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(4'd4, 4'd15, 4'd15, 8'h0F, 0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
